// File: rtl/hamming_decode_arbiter_if.sv
// Request/response bus of the two-requester Hamming(7,4) decoder.
// The master side is the requester/downstream environment; the slave side is the decoder.
interface hamming_decode_arbiter_if;
  logic       en;
  logic [1:0] req_valid;
  logic [6:0] code0;
  logic [6:0] code1;
  logic [1:0] req_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic       error_corrected;
  logic       out_src;
  logic [7:0] err_count;
  logic       clr_count;

  modport slave (
    input  en, req_valid, code0, code1, out_ready, clr_count,
    output req_ready, out_valid, data_out, syndrome, error_corrected, out_src, err_count
  );

  modport master (
    output en, req_valid, code0, code1, out_ready, clr_count,
    input  req_ready, out_valid, data_out, syndrome, error_corrected, out_src, err_count
  );
endinterface

// File: rtl/hamming_decode_arbiter.sv
// Round-robin arbiter feeding one shared Hamming(7,4) single-error-correcting decode
// stage into a one-entry result register, with a saturating corrected-word counter.
module hamming_decode_arbiter (
  input  logic                            clk,
  input  logic                            rst_n,
  hamming_decode_arbiter_if.slave         bus
);
  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic                grant;
  logic                grant_idx;
  logic                prio;
  logic [1:0]          ready;
  logic [CODE_W-1:0]   code;
  logic [CODE_W-1:0]   fixed;
  logic [SYN_W-1:0]    syn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Grant selection and next state; ready never looks at the codewords.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_idx = 1'b0;
    ready     = 2'b00;
    if (rst_n && bus.en && (state == EMPTY || bus.out_ready)) begin
      case (bus.req_valid)
        2'b01:   begin grant = 1'b1; grant_idx = 1'b0; end
        2'b10:   begin grant = 1'b1; grant_idx = 1'b1; end
        2'b11:   begin grant = 1'b1; grant_idx = prio; end
        default: begin grant = 1'b0; grant_idx = 1'b0; end
      endcase
    end
    if (grant)                               state_nxt = FULL;
    else if (state == FULL && bus.out_ready) state_nxt = EMPTY;
    if (grant) ready = 2'b01 << grant_idx;
  end

  // Shared decode of the granted codeword; position p lives at code[p-1].
  always_comb begin
    code   = grant_idx ? bus.code1 : bus.code0;
    syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    fixed  = code;
    if (syn != '0) fixed = code ^ (CODE_W'(1) << (syn - SYN_W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out        <= '0;
      bus.syndrome        <= '0;
      bus.error_corrected <= 1'b0;
      bus.out_src         <= 1'b0;
      bus.err_count       <= '0;
      prio                <= 1'b0;
    end else begin
      if (grant) begin
        bus.data_out        <= DATA_W'({fixed[6], fixed[5], fixed[4], fixed[2]});
        bus.syndrome        <= syn;
        bus.error_corrected <= |syn;
        bus.out_src         <= grant_idx;
        prio                <= ~grant_idx;
      end
      // Clear wins over a same-cycle increment.
      if (bus.clr_count)
        bus.err_count <= '0;
      else if (grant && (|syn) && bus.err_count != {CNT_W{1'b1}})
        bus.err_count <= bus.err_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.req_ready = ready;
endmodule
